nes_pad_poller: RTL and testbench

//  Parametrised NES/SNES controller poller: generates latch and serial clock, shifts in

---
 rtl/nes_pad_poller_if.sv | 25 ++
 rtl/nes_pad_poller.sv | 135 +++++++++++++
 tb/tb_nes_pad_poller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_poller_if.sv
// rtl/nes_pad_poller_if.sv - pad pins and snapshot signals of the NES/SNES pad poller
interface nes_pad_poller_if #(
    parameter int NUM_PADS = 2,
    parameter int BITS     = 8
);
    logic                     enable;
    logic                     poll_now;
    logic [NUM_PADS-1:0]      nes_data;
    logic                     nes_latch;
    logic                     nes_clk;
    logic [NUM_PADS*BITS-1:0] buttons;
    logic                     valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        input  enable, poll_now, nes_data,
        output nes_latch, nes_clk, buttons, valid, busy, overrun
    );

    modport slave (
        output enable, poll_now, nes_data,
        input  nes_latch, nes_clk, buttons, valid, busy, overrun
    );
endinterface

// File: rtl/nes_pad_poller.sv
// rtl/nes_pad_poller.sv - latch/clock generator and parallel shift-in of NES/SNES pads
module nes_pad_poller #(
    parameter int NUM_PADS    = 2,
    parameter int BITS        = 8,
    parameter int CLK_DIV     = 6,
    parameter int POLL_PERIOD = 2000
) (
    input  logic              clk,
    input  logic              reset,
    nes_pad_poller_if.master  pad_bus
);
    localparam int PH_W   = $clog2(2 * CLK_DIV);
    localparam int BIT_W  = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int TMR_W  = $clog2(POLL_PERIOD);
    localparam int SNAP_W = NUM_PADS * BITS;

    localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [SNAP_W-1:0] shift_q, shift_d;
    logic              overrun_q, overrun_d;
    logic              latch_q, nclk_q, busy_q, valid_q;
    logic [SNAP_W-1:0] buttons_q;
    logic              tick;

    assign tick = pad_bus.enable && (timer_q == TMR_LAST);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        timer_d   = '0;
        overrun_d = overrun_q | (tick && (state_q != ST_IDLE));

        if (pad_bus.enable && !tick) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                bit_d   = '0;
                if (pad_bus.poll_now || tick) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    phase_d = '0;
                    state_d = ST_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_q == HALF_LAST) begin
                    // Sample just before the rising nes_clk edge that shifts the pads on.
                    for (int p = 0; p < NUM_PADS; p++) begin
                        shift_d[p * BITS + int'(bit_q)] = pad_bus.nes_data[p];
                    end
                    phase_d = '0;
                    state_d = (bit_q == BIT_LAST) ? ST_DONE : ST_HIGH;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    bit_d   = bit_q + 1'b1;
                    state_d = ST_LOW;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            // Pin and status outputs are decoded from the next state so they are registered.
            latch_q   <= (state_d == ST_LATCH);
            nclk_q    <= (state_d == ST_HIGH);
            busy_q    <= (state_d != ST_IDLE);
            valid_q   <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                buttons_q <= ~shift_d;
            end
        end
    end

    assign pad_bus.nes_latch = latch_q;
    assign pad_bus.nes_clk   = nclk_q;
    assign pad_bus.busy      = busy_q;
    assign pad_bus.valid     = valid_q;
    assign pad_bus.overrun   = overrun_q;
    assign pad_bus.buttons   = buttons_q;
endmodule

// File: tb/tb_nes_pad_poller.sv
// tb/tb_nes_pad_poller.sv - directed vectors and corner sequences for nes_pad_poller
module tb_nes_pad_poller;
    localparam int CD       = 2;
    localparam int NBITS    = 8;
    localparam int POLL_LEN = (2 * NBITS + 1) * CD + 1;

    logic clk;
    logic reset;

    nes_pad_poller_if #(.NUM_PADS(2), .BITS(NBITS)) bus ();
    nes_pad_poller_if #(.NUM_PADS(2), .BITS(NBITS)) bus6 ();

    nes_pad_poller #(.NUM_PADS(2), .BITS(NBITS), .CLK_DIV(CD), .POLL_PERIOD(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .pad_bus (bus)
    );

    nes_pad_poller #(.NUM_PADS(2), .BITS(NBITS), .CLK_DIV(CD), .POLL_PERIOD(20)) dut6 (
        .clk     (clk),
        .reset   (reset),
        .pad_bus (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: {pad1, pad0} pressed masks; 4021-style shifter loads on latch, shifts on nes_clk rise.
    logic [15:0] pad_btn;
    logic [15:0] pad_sh;
    always @(posedge bus.nes_clk or posedge bus.nes_latch) begin
        if (bus.nes_latch) pad_sh <= pad_btn;
        else               pad_sh <= {1'b0, pad_sh[15:9], 1'b0, pad_sh[7:1]};
    end
    assign bus.nes_data  = ~{pad_sh[8], pad_sh[0]};
    assign bus6.nes_data = 2'b11;

    wire [20:0] outs_main = {bus.nes_latch, bus.nes_clk, bus.busy, bus.valid, bus.overrun, bus.buttons};
    wire [20:0] outs_six  = {bus6.nes_latch, bus6.nes_clk, bus6.busy, bus6.valid, bus6.overrun, bus6.buttons};

    int applied    = 0;
    int miscompares = 0;
    logic [15:0] prev_buttons;

    typedef struct {
        logic [7:0]  pad0;
        logic [7:0]  pad1;
        bit          poke;
        logic [15:0] exp_buttons;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_poll(input string name, input logic [15:0] exp_btn, input bit poke);
        logic [63:0] lm, nm, bm, vm, elm, enm, ebm, evm;
        bit hold_ok;
        lm = '0; nm = '0; bm = '0; vm = '0;
        elm = '0; enm = '0; ebm = '0; evm = '0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 2 * CD; k++) elm[k] = 1'b1;
        for (int k = 1; k <= POLL_LEN; k++) ebm[k] = 1'b1;
        evm[POLL_LEN] = 1'b1;
        for (int b = 0; b < NBITS - 1; b++)
            for (int j = 0; j < CD; j++) enm[1 + 2 * CD + (2 * b + 1) * CD + j] = 1'b1;

        bus.poll_now = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.poll_now = poke && (k == 10);
            lm[k] = bus.nes_latch;
            nm[k] = bus.nes_clk;
            bm[k] = bus.busy;
            vm[k] = bus.valid;
            if (k < POLL_LEN && bus.buttons !== prev_buttons) hold_ok = 1'b0;
            if (k >= POLL_LEN && bus.buttons !== exp_btn) hold_ok = 1'b0;
        end
        check({name, " latch"},   lm, elm);
        check({name, " nes_clk"}, nm, enm);
        check({name, " busy"},    bm, ebm);
        check({name, " valid"},   vm, evm);
        check({name, " buttons"}, 64'(bus.buttons), 64'(exp_btn));
        check({name, " hold"},    64'(hold_ok), 64'd1);
        check({name, " overrun"}, 64'(bus.overrun), 64'd0);
        prev_buttons = exp_btn;
    endtask

    initial begin
        int vcount;
        int vfirst;
        int vks [$];
        int busy_first;

        vecs[0] = '{pad0: 8'h09, pad1: 8'h00, poke: 1'b0, exp_buttons: 16'h0009};
        vecs[1] = '{pad0: 8'h00, pad1: 8'h80, poke: 1'b0, exp_buttons: 16'h8000};
        vecs[2] = '{pad0: 8'hFF, pad1: 8'hFF, poke: 1'b1, exp_buttons: 16'hFFFF};
        vecs[3] = '{pad0: 8'h5A, pad1: 8'hA5, poke: 1'b0, exp_buttons: 16'hA55A};
        vecs[4] = '{pad0: 8'h80, pad1: 8'h01, poke: 1'b1, exp_buttons: 16'h0180};
        vecs[5] = '{pad0: 8'h00, pad1: 8'h00, poke: 1'b0, exp_buttons: 16'h0000};

        reset = 1'b1;
        pad_btn = 16'h0000;
        bus.enable = 1'b0;  bus.poll_now = 1'b0;
        bus6.enable = 1'b0; bus6.poll_now = 1'b0;
        prev_buttons = 16'h0000;

        // Reset with random control inputs
        for (int i = 0; i < 3; i++) begin
            bus.enable  = 1'($urandom); bus.poll_now  = 1'($urandom);
            bus6.enable = 1'($urandom); bus6.poll_now = 1'($urandom);
            @(negedge clk);
            check($sformatf("reset outs %0d", i), 64'(outs_main), 64'd0);
            check($sformatf("reset outs6 %0d", i), 64'(outs_six), 64'd0);
        end
        bus.enable = 1'b0;  bus.poll_now = 1'b0;
        bus6.enable = 1'b0; bus6.poll_now = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Table of on-demand polls
        for (int v = 0; v < 6; v++) begin
            pad_btn = {vecs[v].pad1, vecs[v].pad0};
            run_poll($sformatf("vec%0d", v), vecs[v].exp_buttons, vecs[v].poke);
            repeat (5) @(negedge clk);
        end

        // Reset in the HIGH phase of bit 4 aborts the poll
        pad_btn = 16'h3C3C;
        bus.poll_now = 1'b1;
        for (int k = 1; k <= 1 + 2 * CD + 9 * CD; k++) begin
            @(negedge clk);
            bus.poll_now = 1'b0;
        end
        check("abort mid_high", 64'({bus.nes_clk, bus.busy}), 64'b11);
        reset = 1'b1;
        #1;
        check("abort outs", 64'(outs_main), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid) vcount++;
        end
        check("abort no_valid", 64'(vcount), 64'd0);
        check("abort buttons", 64'(bus.buttons), 64'd0);
        prev_buttons = 16'h0000;
        pad_btn = 16'h2211;
        run_poll("after_abort", 16'h2211, 1'b0);

        // Periodic polling from reset, then enable dropped mid-poll
        reset = 1'b1;
        pad_btn = 16'h8000;
        bus.enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vks.delete();
        for (int k = 1; k <= 450; k++) begin
            @(negedge clk);
            if (bus.valid) vks.push_back(k);
            if (k == 325) begin
                check("periodic busy_at_drop", 64'(bus.busy), 64'd1);
                bus.enable = 1'b0;
            end
        end
        check("periodic valid_count", 64'(vks.size()), 64'd5);
        for (int i = 0; i < 5 && i < vks.size(); i++)
            check($sformatf("periodic valid_at %0d", i), 64'(vks[i]), 64'(98 + 64 * i));
        check("periodic buttons", 64'(bus.buttons), 64'h8000);
        check("periodic overrun", 64'(bus.overrun), 64'd0);

        // Short period: poll_now coincides with first tick, second tick overruns
        bus6.enable = 1'b1;
        vks.delete();
        busy_first = 0;
        vfirst = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 19) bus6.poll_now = 1'b1;
            if (k == 20) bus6.poll_now = 1'b0;
            if (bus6.busy && busy_first == 0) busy_first = k;
            if (bus6.valid) vks.push_back(k);
            if (k == 39) check("overrun before_tick2", 64'(bus6.overrun), 64'd0);
            if (k == 40) check("overrun at_tick2", 64'(bus6.overrun), 64'd1);
        end
        if (vks.size() > 0) vfirst = vks[0];
        check("short busy_first", 64'(busy_first), 64'd20);
        check("short valid_count", 64'(vks.size()), 64'd2);
        check("short valid_first", 64'(vfirst), 64'd54);
        check("overrun sticky", 64'(bus6.overrun), 64'd1);
        check("short buttons", 64'(bus6.buttons), 64'd0);
        bus6.enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
